// File: rtl/branch_resolve.sv
// branch_resolve: in-flight branch FIFO that resolves predictions, trains the PHT and redirects on mispredicts.
// Optional statistics counters are built only when BRANCH_RESOLVE_STATS_EN is defined.
`default_nettype none

module branch_resolve #(
  parameter int DEPTH = 4,
  parameter int GHR_W = 6,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  input  logic                       push_pred,
  input  logic [GHR_W-1:0]           push_ghr,
  input  logic [PC_W-1:0]            push_target,
  input  logic [PC_W-1:0]            push_fallthru,
  output logic                       push_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  output logic                       mispredict,
  output logic [PC_W-1:0]            redirect_pc,
  output logic [GHR_W-1:0]           repair_ghr,
  output logic                       upd_valid,
  output logic                       upd_taken,
  output logic [GHR_W-1:0]           upd_ghr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err,
  output logic                       underflow_err,
  output logic [15:0]                stat_branches,
  output logic [15:0]                stat_mispredicts
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t state, state_next;

  logic             pred_mem   [DEPTH];
  logic [GHR_W-1:0] ghr_mem    [DEPTH];
  logic [PC_W-1:0]  target_mem [DEPTH];
  logic [PC_W-1:0]  fall_mem   [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;

  logic             run, full, empty;
  logic             push_acc, pop, mis_det, ovf_set, unf_set;
  logic             head_pred;
  logic [GHR_W-1:0] head_ghr;
  logic [PC_W-1:0]  head_target, head_fall;

  assign run   = (state == RUN);
  assign full  = (count == FULL);
  assign empty = (count == '0);

  // Gated by rst so the port reads 0 while reset is held.
  assign push_ready = rst & run & ~full;
  assign push_acc   = push_valid & push_ready;

  assign head_pred   = pred_mem[rd_ptr];
  assign head_ghr    = ghr_mem[rd_ptr];
  assign head_target = target_mem[rd_ptr];
  assign head_fall   = fall_mem[rd_ptr];

  // A same-cycle push never satisfies a resolve; it only suppresses underflow.
  assign pop     = resolve_valid & run & ~empty;
  assign mis_det = pop & (head_pred != resolve_taken);
  assign ovf_set = push_valid & run & full;
  assign unf_set = resolve_valid & run & empty & ~push_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mis_det) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      pred_mem[wr_ptr]   <= push_pred;
      ghr_mem[wr_ptr]    <= push_ghr;
      target_mem[wr_ptr] <= push_target;
      fall_mem[wr_ptr]   <= push_fallthru;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mis_det) begin
      // Everything younger than the mispredicted branch is wrong-path, including a same-cycle push.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      case ({push_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      upd_ghr       <= '0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      repair_ghr    <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      upd_valid   <= pop;
      upd_taken   <= pop & resolve_taken;
      upd_ghr     <= pop ? head_ghr : '0;
      mispredict  <= mis_det;
      redirect_pc <= mis_det ? (resolve_taken ? head_target : head_fall) : '0;
      repair_ghr  <= mis_det ? {head_ghr[GHR_W-2:0], resolve_taken} : '0;
      if (ovf_set) overflow_err  <= 1'b1;
      if (unf_set) underflow_err <= 1'b1;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop && stat_branches != 16'hFFFF)
        stat_branches <= stat_branches + 16'd1;
      if (mis_det && stat_mispredicts != 16'hFFFF)
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// Directed table-driven bench for branch_resolve (DEPTH=4, GHR_W=6, PC_W=32).
`default_nettype none

module tb_branch_resolve;

  localparam int DEPTH = 4;
  localparam int GHR_W = 6;
  localparam int PC_W  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid, push_pred, resolve_valid, resolve_taken;
  logic [GHR_W-1:0] push_ghr;
  logic [PC_W-1:0]  push_target, push_fallthru;
  logic             push_ready, mispredict, upd_valid, upd_taken;
  logic [PC_W-1:0]  redirect_pc;
  logic [GHR_W-1:0] repair_ghr, upd_ghr;
  logic [2:0]       count;
  logic             overflow_err, underflow_err;
  logic [15:0]      stat_branches, stat_mispredicts;

  always #5 clk = ~clk;

  branch_resolve #(.DEPTH(DEPTH), .GHR_W(GHR_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pred(push_pred), .push_ghr(push_ghr),
    .push_target(push_target), .push_fallthru(push_fallthru), .push_ready(push_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .repair_ghr(repair_ghr),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_ghr(upd_ghr),
    .count(count), .overflow_err(overflow_err), .underflow_err(underflow_err),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic pv; logic pp; logic [5:0] pg; logic [31:0] pt; logic [31:0] pf; logic rv; logic rt;
    logic mp; logic [31:0] pc; logic [5:0] rg; logic uv; logic ut; logic [5:0] ug;
    logic [2:0] cnt; logic pr; logic ov; logic un;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic pp, input logic [5:0] pg, input logic [31:0] pt,
                       input logic [31:0] pf, input logic rv, input logic rt);
    push_valid = pv; push_pred = pp; push_ghr = pg; push_target = pt; push_fallthru = pf;
    resolve_valid = rv; resolve_taken = rt;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mispredict"},  32'(mispredict), 32'd0);
    check({tag, ".redirect_pc"}, redirect_pc, 32'd0);
    check({tag, ".repair_ghr"},  32'(repair_ghr), 32'd0);
    check({tag, ".upd_valid"},   32'(upd_valid), 32'd0);
    check({tag, ".upd_taken"},   32'(upd_taken), 32'd0);
    check({tag, ".upd_ghr"},     32'(upd_ghr), 32'd0);
    check({tag, ".count"},       32'(count), 32'd0);
    check({tag, ".push_ready"},  32'(push_ready), 32'd0);
    check({tag, ".overflow"},    32'(overflow_err), 32'd0);
    check({tag, ".underflow"},   32'(underflow_err), 32'd0);
    check({tag, ".stat_br"},     32'(stat_branches), 32'd0);
    check({tag, ".stat_mp"},     32'(stat_mispredicts), 32'd0);
  endtask

  initial begin
    //           pv    pp    pg         pt       pf       rv    rt    mp    pc      rg         uv    ut    ug         cnt   pr    ov    un
    vecs[0]  = '{1'b1, 1'b1, 6'b000101, 32'h100, 32'h20,  1'b0, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b0, 1'b0, 6'b000000, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 6'b000000, 32'h0,   32'h0,   1'b1, 1'b1, 1'b0, 32'h0,  6'b000000, 1'b1, 1'b1, 6'b000101, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 6'b101010, 32'h200, 32'h48,  1'b0, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b0, 1'b0, 6'b000000, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 6'b000000, 32'h0,   32'h0,   1'b1, 1'b0, 1'b1, 32'h48, 6'b010100, 1'b1, 1'b0, 6'b101010, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 6'b111111, 32'h600, 32'h604, 1'b1, 1'b1, 1'b0, 32'h0,  6'b000000, 1'b0, 1'b0, 6'b000000, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 6'b000001, 32'h300, 32'h304, 1'b0, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b0, 1'b0, 6'b000000, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 6'b000010, 32'h310, 32'h314, 1'b0, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b0, 1'b0, 6'b000000, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 6'b000011, 32'h320, 32'h324, 1'b0, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b0, 1'b0, 6'b000000, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 6'b000100, 32'h330, 32'h334, 1'b0, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b0, 1'b0, 6'b000000, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 6'b111100, 32'h340, 32'h344, 1'b0, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b0, 1'b0, 6'b000000, 3'd4, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 6'b000000, 32'h0,   32'h0,   1'b1, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b1, 1'b0, 6'b000001, 3'd3, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 6'b000000, 32'h0,   32'h0,   1'b1, 1'b1, 1'b0, 32'h0,  6'b000000, 1'b1, 1'b1, 6'b000010, 3'd2, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 6'b000000, 32'h0,   32'h0,   1'b1, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b1, 1'b0, 6'b000011, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 6'b000000, 32'h0,   32'h0,   1'b1, 1'b1, 1'b0, 32'h0,  6'b000000, 1'b1, 1'b1, 6'b000100, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 6'b111000, 32'h400, 32'h408, 1'b0, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b0, 1'b0, 6'b000000, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 6'b000111, 32'h500, 32'h508, 1'b1, 1'b1, 1'b0, 32'h0,  6'b000000, 1'b1, 1'b1, 6'b111000, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 6'b000000, 32'h0,   32'h0,   1'b1, 1'b0, 1'b0, 32'h0,  6'b000000, 1'b1, 1'b0, 6'b000111, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 6'b000000, 32'h0,   32'h0,   1'b1, 1'b1, 1'b0, 32'h0,  6'b000000, 1'b0, 1'b0, 6'b000000, 3'd0, 1'b1, 1'b1, 1'b1};

    idle();
    rst = 1'b0;
    #1;
    check_all_zero("reset");
    do_reset();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].pv, vecs[i].pp, vecs[i].pg, vecs[i].pt, vecs[i].pf, vecs[i].rv, vecs[i].rt);
      tick();
      check($sformatf("v%0d.mispredict", i), 32'(mispredict), 32'(vecs[i].mp));
      check($sformatf("v%0d.redirect_pc", i), redirect_pc, vecs[i].pc);
      check($sformatf("v%0d.repair_ghr", i), 32'(repair_ghr), 32'(vecs[i].rg));
      check($sformatf("v%0d.upd_valid", i), 32'(upd_valid), 32'(vecs[i].uv));
      check($sformatf("v%0d.upd_taken", i), 32'(upd_taken), 32'(vecs[i].ut));
      check($sformatf("v%0d.upd_ghr", i), 32'(upd_ghr), 32'(vecs[i].ug));
      check($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d.push_ready", i), 32'(push_ready), 32'(vecs[i].pr));
      check($sformatf("v%0d.overflow", i), 32'(overflow_err), 32'(vecs[i].ov));
      check($sformatf("v%0d.underflow", i), 32'(underflow_err), 32'(vecs[i].un));
    end
    idle();

    // Mispredict on the head while a push is presented in the same cycle.
    do_reset();
    drive(1'b1, 1'b1, 6'b110011, 32'h700, 32'h708, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 6'b001100, 32'h710, 32'h718, 1'b0, 1'b0);
    tick();
    check("mp_push.count_before", 32'(count), 32'd2);
    drive(1'b1, 1'b1, 6'b010101, 32'h720, 32'h728, 1'b1, 1'b0);
    tick();
    check("mp_push.mispredict", 32'(mispredict), 32'd1);
    check("mp_push.redirect_pc", redirect_pc, 32'h708);
    check("mp_push.repair_ghr", 32'(repair_ghr), 32'(6'b100110));
    check("mp_push.count", 32'(count), 32'd0);
    check("mp_push.push_ready_flush", 32'(push_ready), 32'd0);
    idle();
    tick();
    check("mp_push.mispredict_gone", 32'(mispredict), 32'd0);
    check("mp_push.count_after", 32'(count), 32'd0);
    check("mp_push.overflow", 32'(overflow_err), 32'd0);
    check("mp_push.push_ready_run", 32'(push_ready), 32'd1);
    drive(1'b1, 1'b1, 6'b011110, 32'h730, 32'h738, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    check("mp_push.next_upd_ghr", 32'(upd_ghr), 32'(6'b011110));
    check("mp_push.next_mispredict", 32'(mispredict), 32'd0);
    check("mp_push.next_count", 32'(count), 32'd0);
    idle();

    // Statistics: three resolves, one of them mispredicted.
    do_reset();
    drive(1'b1, 1'b1, 6'd1, 32'h10, 32'h18, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b1);  tick();
    drive(1'b1, 1'b0, 6'd2, 32'h20, 32'h28, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0);  tick();
    drive(1'b1, 1'b1, 6'd3, 32'h30, 32'h38, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0);  tick();
    check("stats.mispredict", 32'(mispredict), 32'd1);
    idle();
    tick();
`ifdef BRANCH_RESOLVE_STATS_EN
    check("stats.branches", 32'(stat_branches), 32'd3);
    check("stats.mispredicts", 32'(stat_mispredicts), 32'd1);
`else
    check("stats.branches", 32'(stat_branches), 32'd0);
    check("stats.mispredicts", 32'(stat_mispredicts), 32'd0);
`endif

    // Underflow, then asynchronous reset while a mispredict pulse is live.
    do_reset();
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    check("underflow.flag", 32'(underflow_err), 32'd1);
    check("underflow.upd_valid", 32'(upd_valid), 32'd0);
    check("underflow.count", 32'(count), 32'd0);
    drive(1'b1, 1'b0, 6'b000011, 32'h800, 32'h808, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    tick();
    check("async.mispredict_pre", 32'(mispredict), 32'd1);
    check("async.redirect_pre", redirect_pc, 32'h800);
    idle();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
